// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: FSM states, pitch codes, ROM entry
// layout and the pitch-to-half-period table derived from the clock frequency.
package melody_sequencer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_NOTE, ST_GAP} state_e;

    typedef struct packed {
        logic [3:0] pitch;
        logic [3:0] dur;
    } rom_entry_t;

    localparam logic [3:0] P_REST = 4'd0;
    localparam logic [3:0] P_C5   = 4'd1;
    localparam logic [3:0] P_D5   = 4'd3;
    localparam logic [3:0] P_E5   = 4'd5;
    localparam logic [3:0] P_F5   = 4'd6;
    localparam logic [3:0] P_G5   = 4'd8;
    localparam logic [3:0] P_A5   = 4'd10;
    localparam logic [3:0] P_B5   = 4'd12;
    localparam logic [3:0] P_C6   = 4'd13;
    localparam logic [3:0] P_D6   = 4'd14;
    localparam logic [3:0] P_E6   = 4'd15;

    typedef logic [15:0][23:0] hp_table_t;

    // Equal-tempered frequencies in millihertz, A4 = 440 Hz.
    function automatic longint pitch_mhz(int code);
        case (code)
            1:  return 64'd523251;
            2:  return 64'd554365;
            3:  return 64'd587330;
            4:  return 64'd622254;
            5:  return 64'd659255;
            6:  return 64'd698456;
            7:  return 64'd739989;
            8:  return 64'd783991;
            9:  return 64'd830609;
            10: return 64'd880000;
            11: return 64'd932328;
            12: return 64'd987767;
            13: return 64'd1046502;
            14: return 64'd1174659;
            15: return 64'd1318510;
            default: return 64'd0;
        endcase
    endfunction

    // round(clk/(2f)); entry 0 stays 0 so a rest reads back as silence.
    function automatic hp_table_t hp_table(longint clk_hz);
        hp_table_t t;
        longint    f;
        t = '0;
        for (int i = 1; i < 16; i++) begin
            f    = pitch_mhz(i);
            t[i] = 24'((clk_hz * 1000 + f) / (2 * f));
        end
        return t;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// 32x8 synchronous song ROM, one-cycle read latency. Entry = {pitch[3:0], dur[3:0]}.
module melody_rom
    import melody_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic [4:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk_i) begin
        case (addr_i)
            5'd0:    data_q <= {P_A5,   4'd1};
            5'd1:    data_q <= {P_C5,   4'd2};
            5'd2:    data_q <= {P_REST, 4'd1};
            5'd3:    data_q <= {P_E6,   4'd0};
            5'd4:    data_q <= {P_G5,   4'd2};
            5'd5:    data_q <= {P_E5,   4'd2};
            5'd6:    data_q <= {P_C5,   4'd4};
            5'd7:    data_q <= {P_REST, 4'd2};
            5'd8:    data_q <= {P_D5,   4'd2};
            5'd9:    data_q <= {P_F5,   4'd2};
            5'd10:   data_q <= {P_A5,   4'd2};
            5'd11:   data_q <= {P_B5,   4'd2};
            5'd12:   data_q <= {P_C6,   4'd4};
            5'd13:   data_q <= {P_D6,   4'd2};
            5'd14:   data_q <= {P_C6,   4'd2};
            5'd15:   data_q <= {P_C6,   4'd8};
            default: data_q <= {P_REST, 4'd1};
        endcase
    end

    assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM and feeds half-period/enable to the buzzer tone stage.
// Define MELODY_LOOP_EN to repeat the song until STOP instead of a single pass.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int TEMPO_TICKS = 750000,
    parameter int GAP_CYC     = 120000,
    parameter int SONG_LEN    = 16
)(
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic        PLAY,
    input  logic        STOP,
    output logic [23:0] HALF_PERIOD,
    output logic        TONE_EN,
    output logic        BUSY,
    output logic [4:0]  NOTE_IDX,
    output logic        DONE
);

    localparam hp_table_t   HP_TAB   = hp_table(longint'(CLK_HZ));
    localparam logic [4:0]  LAST_IDX = 5'(SONG_LEN - 1);
    localparam logic [23:0] TEMPO    = 24'(TEMPO_TICKS);
    localparam logic [23:0] NOTE_SUB = 24'(GAP_CYC + 1);
    localparam logic [23:0] GAP_LOAD = 24'(GAP_CYC - 1);

    state_e      state_q;
    logic [23:0] timer_q;
    logic [23:0] hp_q;
    logic        tone_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;

    logic [7:0]  rom_data;
    rom_entry_t  entry;
    logic [3:0]  dur_eff;
    logic [23:0] note_load;
    logic        timer_zero;
    logic        last_note;

    assign entry      = rom_entry_t'(rom_data);
    assign dur_eff    = (entry.dur == 4'd0) ? 4'd1 : entry.dur;
    assign note_load  = 24'(dur_eff) * TEMPO - NOTE_SUB;
    assign timer_zero = (timer_q == '0);
    assign last_note  = (idx_q == LAST_IDX);

    // The ROM is addressed with the next index so its output is valid during FETCH.
    always_comb begin
        idx_d = idx_q;
        if (state_q == ST_IDLE)
            idx_d = '0;
        else if (state_q == ST_GAP && timer_zero)
            idx_d = last_note ? 5'd0 : idx_q + 5'd1;
    end

    melody_rom u_rom (
        .clk_i  (CLK_IN),
        .addr_i (idx_d),
        .data_o (rom_data)
    );

    always_ff @(posedge CLK_IN) begin
        done_q <= 1'b0;
        if (!RST_N || (STOP && state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            hp_q    <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            idx_q <= idx_d;
            case (state_q)
                ST_IDLE: begin
                    if (PLAY && !STOP) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_NOTE;
                    timer_q <= note_load;
                    hp_q    <= HP_TAB[entry.pitch];
                    tone_q  <= (entry.pitch != P_REST);
                end
                ST_NOTE: begin
                    if (timer_zero) begin
                        state_q <= ST_GAP;
                        timer_q <= GAP_LOAD;
                        hp_q    <= '0;
                        tone_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        if (!last_note) begin
                            state_q <= ST_FETCH;
                        end else begin
                            done_q <= 1'b1;
`ifdef MELODY_LOOP_EN
                            state_q <= ST_FETCH;
`else
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign HALF_PERIOD = hp_q;
    assign TONE_EN     = tone_q;
    assign BUSY        = busy_q;
    assign NOTE_IDX    = idx_q;
    assign DONE        = done_q;

endmodule
